m_wb_elastic_stage: RTL

- Parametrised successor to the fixed M/WB pipeline register: a DEPTH-entry in-order elastic buffer between the Memory and Writeback stages.
- Adds valid/ready backpressure, occupancy reporting, and ROB-based flush that kills either every entry or only entries younger than a given rob_id (wrap-around aware).
- The payload is identical to the current M/WB bundle.

---
 rtl/m_wb_pkg.sv | 29 ++
 rtl/m_wb_elastic_stage_rob_age_cmp.sv | 13 +
 rtl/m_wb_elastic_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/m_wb_pkg.sv
// Shared types and helpers for the M/WB elastic stage: payload bundle,
// width constants and the wrap-aware ROB age comparison.
package m_wb_pkg;

  localparam int unsigned WORD_SIZE       = 32;
  localparam int unsigned INSTR_TYPE_SZ   = 3;
  localparam int unsigned ROB_ENTRY_WIDTH = 3;

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic                       exception;
    logic [WORD_SIZE-1:0]       virtual_addr_exception;
    logic [WORD_SIZE-1:0]       aluResult;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
  } m_wb_payload_t;

  // True when id is strictly younger than ref_id, ages measured from the ROB head.
  function automatic logic rob_younger(input logic [ROB_ENTRY_WIDTH-1:0] id,
                                       input logic [ROB_ENTRY_WIDTH-1:0] ref_id,
                                       input logic [ROB_ENTRY_WIDTH-1:0] head);
    logic [ROB_ENTRY_WIDTH-1:0] age_id;
    logic [ROB_ENTRY_WIDTH-1:0] age_ref;
    age_id  = id - head;
    age_ref = ref_id - head;
    return age_id > age_ref;
  endfunction

endpackage

// File: rtl/m_wb_elastic_stage_rob_age_cmp.sv
// Combinational ROB age compare: flags an id as younger than the flush id.
module rob_age_cmp
  import m_wb_pkg::*;
(
  input  logic [ROB_ENTRY_WIDTH-1:0] i_id,
  input  logic [ROB_ENTRY_WIDTH-1:0] i_ref_id,
  input  logic [ROB_ENTRY_WIDTH-1:0] i_head,
  output logic                       o_younger_c
);

  assign o_younger_c = rob_younger(i_id, i_ref_id, i_head);

endmodule

// File: rtl/m_wb_elastic_stage.sv
// DEPTH-entry in-order elastic buffer between Memory and Writeback with
// valid/ready handshake, occupancy reporting and ROB-age based flush.
module m_wb_elastic_stage #(
  parameter int unsigned WORD_SIZE       = m_wb_pkg::WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ   = m_wb_pkg::INSTR_TYPE_SZ,
  parameter int unsigned ROB_ENTRY_WIDTH = m_wb_pkg::ROB_ENTRY_WIDTH,
  parameter int unsigned DEPTH           = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic                       exception,
  input  logic [WORD_SIZE-1:0]       virtual_addr_exception,
  input  logic [WORD_SIZE-1:0]       aluResult,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic                       exception_out,
  output logic [WORD_SIZE-1:0]       virtual_addr_exception_out,
  output logic [WORD_SIZE-1:0]       aluResult_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  input  logic                       flush_valid,
  input  logic                       flush_all,
  input  logic [ROB_ENTRY_WIDTH-1:0] flush_rob_id,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_head,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import m_wb_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  m_wb_payload_t    r_mem [DEPTH];

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_push_kept;
  logic             w_in_younger;
  logic [DEPTH-1:0] w_slot_younger;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_slot;
  logic [CNT_W-1:0] w_count_pop;
  logic [CNT_W-1:0] w_keep;
  logic [CNT_W-1:0] w_count_nxt;
  m_wb_payload_t    w_wr_data;

  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_age
    rob_age_cmp u_age (
      .i_id        (r_mem[g].rob_id),
      .i_ref_id    (flush_rob_id),
      .i_head      (rob_head),
      .o_younger_c (w_slot_younger[g])
    );
  end

  rob_age_cmp u_age_in (
    .i_id        (rob_id),
    .i_ref_id    (flush_rob_id),
    .i_head      (rob_head),
    .o_younger_c (w_in_younger)
  );

  // Pop first, then flush trims a suffix of survivors, then the push lands at the new tail.
  always_comb begin
    w_push      = in_valid & w_in_ready;
    w_pop       = w_out_valid & out_ready;
    w_head_nxt  = r_head + PTR_W'(w_pop);
    w_count_pop = r_count - CNT_W'(w_pop);
    w_keep      = w_count_pop;
    w_slot      = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      w_slot = w_head_nxt + PTR_W'(k);
      if (flush_valid && (CNT_W'(k) < w_count_pop) &&
          (flush_all || w_slot_younger[w_slot])) begin
        w_keep = CNT_W'(k);
      end
    end
    w_push_kept = w_push & ~(flush_valid & (flush_all | w_in_younger));
    w_wr_ptr    = w_head_nxt + PTR_W'(w_keep);
    w_tail_nxt  = w_wr_ptr + PTR_W'(w_push_kept);
    w_count_nxt = w_keep + CNT_W'(w_push_kept);
    w_wr_data.instruction_type       = instruction_type;
    w_wr_data.pc                     = pc;
    w_wr_data.exception              = exception;
    w_wr_data.virtual_addr_exception = virtual_addr_exception;
    w_wr_data.aluResult              = aluResult;
    w_wr_data.rob_id                 = rob_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      if (w_push_kept) begin
        r_mem[w_wr_ptr] <= w_wr_data;
      end
    end
  end

  assign in_ready                   = w_in_ready;
  assign out_valid                  = w_out_valid;
  assign occupancy                  = r_count;
  assign instruction_type_out       = r_mem[r_head].instruction_type;
  assign pc_out                     = r_mem[r_head].pc;
  assign exception_out              = r_mem[r_head].exception;
  assign virtual_addr_exception_out = r_mem[r_head].virtual_addr_exception;
  assign aluResult_out              = r_mem[r_head].aluResult;
  assign rob_id_out                 = r_mem[r_head].rob_id;

  // Protocol checks: occupancy bound, and each push younger than the youngest held entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (r_count <= CNT_W'(DEPTH))
        else $error("m_wb_elastic_stage: occupancy above DEPTH");
      assert (!(w_push && !w_in_ready))
        else $error("m_wb_elastic_stage: push while not ready");
      if (w_push && !flush_valid && (w_count_pop != '0)) begin
        assert (rob_younger(rob_id, r_mem[r_tail - PTR_W'(1)].rob_id, rob_head))
          else $error("m_wb_elastic_stage: non-monotonic rob_id push");
      end
    end
  end

endmodule
